// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fir_tap_sequencer : sample write + tap address walk for a shared-MAC FIR
// Revision 1.0
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TAPS    = 32,
  parameter int MAC_LAT = 2,
  localparam int AW     = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] input_sig,
  input  logic             ready,
  input  logic             clr_overrun,
  output logic             smp_we,
  output logic [AW-1:0]    smp_waddr,
  output logic [WIDTH-1:0] smp_wdata,
  output logic [AW-1:0]    smp_raddr,
  output logic [AW-1:0]    coef_addr,
  output logic             mac_en,
  output logic             mac_clr,
  output logic             res_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [AW-1:0] K_LAST     = AW'(TAPS - 1);
  localparam logic [2:0]    DRAIN_LAST = 3'((MAC_LAT == 0) ? 0 : MAC_LAT - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [2:0]       drain_q, drain_d;
  logic             smp_we_q, smp_we_d;
  logic [AW-1:0]    smp_waddr_q, smp_waddr_d;
  logic [WIDTH-1:0] smp_wdata_q, smp_wdata_d;
  logic [AW-1:0]    smp_raddr_q, smp_raddr_d;
  logic [AW-1:0]    coef_addr_q, coef_addr_d;
  logic             mac_en_q, mac_en_d;
  logic             mac_clr_q, mac_clr_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  // All outputs are registered, so each is computed from the state being entered.
  // coef_addr doubles as the tap counter k.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    drain_d     = drain_q;
    smp_we_d    = 1'b0;
    smp_waddr_d = smp_waddr_q;
    smp_wdata_d = smp_wdata_q;
    smp_raddr_d = smp_raddr_q;
    coef_addr_d = coef_addr_q;
    mac_en_d    = 1'b0;
    mac_clr_d   = 1'b0;
    res_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && ready) begin
          state_d     = S_WRITE;
          smp_we_d    = 1'b1;
          smp_waddr_d = wr_ptr_q;
          smp_wdata_d = input_sig;
        end
      end
      S_WRITE: begin
        state_d     = S_MAC;
        mac_en_d    = 1'b1;
        mac_clr_d   = 1'b1;
        coef_addr_d = '0;
        smp_raddr_d = wr_ptr_q;
      end
      S_MAC: begin
        if (coef_addr_q == K_LAST) begin
          drain_d = '0;
          if (MAC_LAT == 0) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          mac_en_d    = 1'b1;
          coef_addr_d = coef_addr_q + 1'b1;
          // Explicit wrap keeps non-power-of-2 lengths inside the delay line.
          smp_raddr_d = (smp_raddr_q == '0) ? K_LAST : smp_raddr_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        wr_ptr_d = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q != S_IDLE) && en && ready) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      drain_q     <= '0;
      smp_we_q    <= 1'b0;
      smp_waddr_q <= '0;
      smp_wdata_q <= '0;
      smp_raddr_q <= '0;
      coef_addr_q <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      drain_q     <= drain_d;
      smp_we_q    <= smp_we_d;
      smp_waddr_q <= smp_waddr_d;
      smp_wdata_q <= smp_wdata_d;
      smp_raddr_q <= smp_raddr_d;
      coef_addr_q <= coef_addr_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign smp_we    = smp_we_q;
  assign smp_waddr = smp_waddr_q;
  assign smp_wdata = smp_wdata_q;
  assign smp_raddr = smp_raddr_q;
  assign coef_addr = coef_addr_q;
  assign mac_en    = mac_en_q;
  assign mac_clr   = mac_clr_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer : scoreboard bench, one default and one TAPS=5/MAC_LAT=0 DUT
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;
  localparam int WIDTH = 16;
  localparam int TA = 32, LA = 2;
  localparam int TB = 5,  LB = 0;
  localparam int AWA = $clog2(TA);
  localparam int AWB = $clog2(TB);

  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, ready = 1'b0, clr_overrun = 1'b0;
  logic [WIDTH-1:0] input_sig = '0;
  always #5 clk = ~clk;

  logic             a_we, a_men, a_mclr, a_rv, a_busy, a_ov;
  logic [AWA-1:0]   a_waddr, a_raddr, a_coef;
  logic [WIDTH-1:0] a_wdata;
  logic             b_we, b_men, b_mclr, b_rv, b_busy, b_ov;
  logic [AWB-1:0]   b_waddr, b_raddr, b_coef;
  logic [WIDTH-1:0] b_wdata;

  fir_tap_sequencer #(.WIDTH(WIDTH), .TAPS(TA), .MAC_LAT(LA)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .input_sig(input_sig), .ready(ready),
    .clr_overrun(clr_overrun), .smp_we(a_we), .smp_waddr(a_waddr), .smp_wdata(a_wdata),
    .smp_raddr(a_raddr), .coef_addr(a_coef), .mac_en(a_men), .mac_clr(a_mclr),
    .res_valid(a_rv), .busy(a_busy), .overrun(a_ov));

  fir_tap_sequencer #(.WIDTH(WIDTH), .TAPS(TB), .MAC_LAT(LB)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .input_sig(input_sig), .ready(ready),
    .clr_overrun(clr_overrun), .smp_we(b_we), .smp_waddr(b_waddr), .smp_wdata(b_wdata),
    .smp_raddr(b_raddr), .coef_addr(b_coef), .mac_en(b_men), .mac_clr(b_mclr),
    .res_valid(b_rv), .busy(b_busy), .overrun(b_ov));

  // kind 0: write {addr,data}; kind 1: tap {raddr,coef,clr}; kind 2: result pulse
  typedef struct { int inst; int kind; int at; int v1; int v2; int v3; } exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0;
  int edge_n = 0, rst_edge = -1;
  int tp[2] = '{TA, TB};
  int lt[2] = '{LA, LB};
  int free_edge[2] = '{0, 0};
  int acc_edge[2]  = '{-1, -1};
  int busy_end[2]  = '{-2, -2};
  int wrp[2]       = '{0, 0};
  int ovm[2]       = '{0, 0};

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, edge_n, act, req);
    end
  endtask

  function automatic int find(input int inst, input int kind);
    for (int j = 0; j < exp_q.size(); j++)
      if (exp_q[j].inst == inst && exp_q[j].kind == kind) return j;
    return -1;
  endfunction

  // Reference model: a sample accepted at edge a is written after edge a, its
  // taps follow on edges a+1..a+T, the result after edge a+1+T+L, and the
  // block can accept again from edge a+3+T+L.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int j = exp_q.size() - 1; j >= 0; j--)
          if (exp_q[j].inst == i) exp_q.delete(j);
        free_edge[i] = 0; acc_edge[i] = -1; busy_end[i] = -2; wrp[i] = 0; ovm[i] = 0;
        rst_edge = edge_n;
      end else begin
        int drop = 0;
        if (en && ready) begin
          if (edge_n >= free_edge[i]) begin
            exp_q.push_back('{i, 0, edge_n, wrp[i], int'(input_sig), 0});
            for (int k = 0; k < tp[i]; k++)
              exp_q.push_back('{i, 1, edge_n + 1 + k,
                                ((wrp[i] - k) % tp[i] + tp[i]) % tp[i], k, (k == 0) ? 1 : 0});
            exp_q.push_back('{i, 2, edge_n + 1 + tp[i] + lt[i], 0, 0, 0});
            acc_edge[i]  = edge_n;
            busy_end[i]  = edge_n + 1 + tp[i] + lt[i];
            free_edge[i] = edge_n + 3 + tp[i] + lt[i];
            wrp[i]       = (wrp[i] + 1) % tp[i];
          end else begin
            drop = 1;
          end
        end
        if (drop != 0) ovm[i] = 1;
        else if (clr_overrun) ovm[i] = 0;
      end
    end
  endtask

  task automatic observe(input int i, input logic we, input int waddr, input int wdata,
                         input int raddr, input int coef, input logic men, input logic mclr,
                         input logic rv, input logic bsy, input logic ov);
    string p;
    int j;
    p = (i == 0) ? "a" : "b";
    for (int x = exp_q.size() - 1; x >= 0; x--) begin
      if (exp_q[x].inst == i && exp_q[x].at < edge_n) begin
        tests++; fails++;
        $display("FAIL %s_missed kind=%0d actual=absent required_edge=%0d now=%0d",
                 p, exp_q[x].kind, exp_q[x].at, edge_n);
        exp_q.delete(x);
      end
    end
    if (rst_edge == edge_n) begin
      check({p, "_rst_we"}, int'(we), 0);
      check({p, "_rst_waddr"}, waddr, 0);
      check({p, "_rst_raddr"}, raddr, 0);
      check({p, "_rst_coef"}, coef, 0);
      check({p, "_rst_men"}, int'(men), 0);
      check({p, "_rst_rv"}, int'(rv), 0);
    end
    check({p, "_busy"}, int'(bsy), (edge_n >= acc_edge[i] && edge_n <= busy_end[i]) ? 1 : 0);
    check({p, "_overrun"}, int'(ov), ovm[i]);
    if (we) begin
      j = find(i, 0);
      if (j < 0) begin
        tests++; fails++;
        $display("FAIL %s_write actual=unexpected_we required=none edge=%0d", p, edge_n);
      end else begin
        check({p, "_write_edge"}, edge_n, exp_q[j].at);
        check({p, "_waddr"}, waddr, exp_q[j].v1);
        check({p, "_wdata"}, wdata, exp_q[j].v2);
        exp_q.delete(j);
      end
    end
    if (men) begin
      j = find(i, 1);
      if (j < 0) begin
        tests++; fails++;
        $display("FAIL %s_tap actual=unexpected_mac_en required=none edge=%0d", p, edge_n);
      end else begin
        check({p, "_tap_edge"}, edge_n, exp_q[j].at);
        check({p, "_raddr"}, raddr, exp_q[j].v1);
        check({p, "_coef"}, coef, exp_q[j].v2);
        check({p, "_mac_clr"}, int'(mclr), exp_q[j].v3);
        exp_q.delete(j);
      end
    end else begin
      check({p, "_mac_clr_idle"}, int'(mclr), 0);
    end
    if (rv) begin
      j = find(i, 2);
      if (j < 0) begin
        tests++; fails++;
        $display("FAIL %s_res_valid actual=unexpected_pulse required=none edge=%0d", p, edge_n);
      end else begin
        check({p, "_res_edge"}, edge_n, exp_q[j].at);
        exp_q.delete(j);
      end
    end
  endtask

  always @(negedge clk) begin
    if (edge_n > 0) begin
      observe(0, a_we, int'(a_waddr), int'(a_wdata), int'(a_raddr), int'(a_coef),
              a_men, a_mclr, a_rv, a_busy, a_ov);
      observe(1, b_we, int'(b_waddr), int'(b_wdata), int'(b_raddr), int'(b_coef),
              b_men, b_mclr, b_rv, b_busy, b_ov);
    end
  end

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
  endtask

  task automatic wait_idle();
    while (edge_n < free_edge[0] || edge_n < free_edge[1]) tick();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // single sample
    input_sig = 16'd100; ready = 1'b1; tick(); ready = 1'b0;
    wait_idle();

    // ready with en low is ignored
    en = 1'b0; ready = 1'b1; repeat (4) tick(); ready = 1'b0; en = 1'b1;

    // overrun set, set beating clear, lone clear
    input_sig = 16'hBEEF; ready = 1'b1; tick(); ready = 1'b0;
    repeat (9) tick();
    ready = 1'b1; tick(); ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1; clr_overrun = 1'b1; tick(); ready = 1'b0; clr_overrun = 1'b0;
    tick();
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    wait_idle();

    // en dropped mid-run
    input_sig = 16'h8001; ready = 1'b1; tick(); ready = 1'b0;
    repeat (4) tick();
    en = 1'b0; wait_idle(); en = 1'b1;

    // reset mid-run, then next sample goes to address 0
    input_sig = 16'h1234; ready = 1'b1; tick(); ready = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    input_sig = 16'h7FFF; ready = 1'b1; tick(); ready = 1'b0;
    wait_idle();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      ready       = ($urandom_range(0, 7) == 0);
      en          = ($urandom_range(0, 15) != 0);
      clr_overrun = ($urandom_range(0, 15) == 0);
      rst_n       = ($urandom_range(0, 599) != 0);
      input_sig   = WIDTH'($urandom);
      tick();
    end
    ready = 1'b0; en = 1'b1; clr_overrun = 1'b0; rst_n = 1'b1;
    repeat (60) tick();

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expectations actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
Sequencer for a time-multiplexed FIR datapath: one shared multiply-accumulate unit, one circular sample RAM and one coefficient ROM, all external to this block. On each accepted input sample it writes the sample into the circular delay line. It then walks all TAPS sample/coefficient address pairs, one per clock, driving the MAC enables, and pulses res_valid when the MAC result is final. It sits between the sample source (the sample/ready strobe path into socket) and the filter datapath.

Parameters:
WIDTH, 16, sample width in bits
TAPS, 32, filter length; any value 2..256, not required to be a power of 2
MAC_LAT, 2, pipeline depth of the external MAC in clocks (0..7)
AW, $clog2(TAPS), address width (localparam, not overridable)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
en  in  1  sequencer enable
input_sig  in  WIDTH  signed input sample
ready  in  1  input sample valid strobe
clr_overrun  in  1  clears the overrun flag
smp_we  out  1  sample RAM write enable
smp_waddr  out  AW  sample RAM write address
smp_wdata  out  WIDTH  sample RAM write data
smp_raddr  out  AW  sample RAM read address
coef_addr  out  AW  coefficient ROM address
mac_en  out  1  MAC consumes operands this cycle
mac_clr  out  1  MAC loads the product instead of accumulating (first tap)
res_valid  out  1  one-cycle pulse: MAC output is the final filtered sample
busy  out  1  high from WRITE through DONE
overrun  out  1  sticky flag: a sample was dropped

Behaviour:
- Clock is clk. Reset is synchronous, active-low, on rst_n. While rst_n=0 at a clock edge: state=IDLE, wr_ptr=0, tap counter k=0, overrun=0. All outputs are 0, and addresses are 0.
- States: IDLE, WRITE, MAC, DRAIN, DONE.
- IDLE: if en=1 and ready=1, register input_sig, then go to WRITE. Otherwise stay in IDLE.
- WRITE (1 cycle): smp_we=1, smp_waddr=wr_ptr, smp_wdata=registered sample. Set k=0, then go to MAC.
- MAC (exactly TAPS cycles, k=0..TAPS-1):
  - mac_en=1, coef_addr=k.
  - smp_raddr=(wr_ptr-k) mod TAPS, wrapping from 0 to TAPS-1 by compare/add, not bit truncation.
  - mac_clr=1 only when k=0.
  - After k=TAPS-1: go to DRAIN, or to DONE if MAC_LAT=0.
- DRAIN: MAC_LAT cycles with mac_en=0, then go to DONE.
- DONE (1 cycle): res_valid=1. wr_ptr <= (wr_ptr==TAPS-1) ? 0 : wr_ptr+1. Return to IDLE.
- Latency: with ready sampled at edge t, WRITE occupies cycle t+1, MAC occupies t+2..t+1+TAPS, and res_valid is high in cycle t+2+TAPS+MAC_LAT. For defaults this is t+36.
- Throughput: at most one sample per TAPS+MAC_LAT+3 clocks (37 for defaults). A 128-clock sample period is always accepted.
- Outputs in states other than those listed above: smp_we, mac_en, mac_clr and res_valid are 0, and addresses hold their last value.
- Read-after-write: the sample written in WRITE is read at k=0 in the following cycle. The RAM must have 1-cycle write-to-read visibility.
- ready while not in IDLE: sample dropped, set overrun=1, current computation unaffected.
- ready in the DONE cycle is also dropped. Sampling restarts only in IDLE.
- overrun: clr_overrun=1 clears it. If a drop and clr_overrun coincide, the set wins.
- en: en=0 blocks acceptance in IDLE only. Dropping en mid-run does not abort; the run completes to DONE. A ready with en=0 is ignored and does not set overrun.
- Reset mid-operation: immediate return to IDLE. No res_valid, wr_ptr=0, and delay-line contents are treated as stale by the datapath.
- Input width: input_sig is stored unmodified (no rounding or saturation). Arithmetic width is the MAC's concern.

Test Plan:
- Reset then single sample: rst_n low 3 clks, then input_sig=100, ready=1 for 1 clk at edge t. Expect smp_we=1, smp_waddr=0, smp_wdata=100 at t+1. mac_clr=1 with smp_raddr=0, coef_addr=0 at t+2. coef_addr=31 at t+33. res_valid single pulse at t+36. busy high t+1..t+36.
- Address wrap: second sample gives wr_ptr=1. Expect smp_raddr sequence 1,0,31,30,…,2 while coef_addr runs 0..31. Run 33 samples and check wr_ptr returns to 0 after the 32nd DONE.
- Non-power-of-2: TAPS=5, MAC_LAT=0, wr_ptr=0. Expect smp_raddr 0,4,3,2,1 and res_valid at t+7. The 5th DONE wraps wr_ptr 4→0.
- Overrun: ready pulsed at t and again at t+10. Expect the second sample not written and overrun=1 from t+11. A clr_overrun pulse coinciding with a further drop leaves overrun=1. A lone clr_overrun clears it next cycle.
- Enable: en=0 with ready=1 gives no smp_we and overrun=0. Deasserting en at t+5 mid-run still produces res_valid at t+36.
- Reset mid-run: rst_n=0 at t+20 for 1 clk. Expect no res_valid, busy=0, mac_en=0 next cycle, and the next sample written at smp_waddr=0.
